// File: rtl/button_conditioner.sv
// N-channel pin conditioner: two-flop synchroniser, debounce, press/release pulses
// and a press/auto-repeat strobe. All outputs are registered; level is 1 = pressed.
module button_conditioner #(
    parameter int CHANNELS        = 9,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000
) (
    input  logic                clock_27mhz,
    input  logic                reset_b,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    // "release" is a reserved word, hence the suffix
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] strobe
);

    localparam int DC_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RT_W   = (RT_MAX < 2) ? 1 : $clog2(RT_MAX);

    localparam logic [DC_W-1:0]     DC_LAST   = DC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RT_W-1:0]     RT_DELAY  = RT_W'(REPEAT_DELAY - 1);
    localparam logic [RT_W-1:0]     RT_PERIOD = RT_W'(REPEAT_PERIOD - 1);
    localparam logic [CHANNELS-1:0] IDLE_RAW  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CHANNELS-1:0] sync_p0;
    logic [CHANNELS-1:0] sync_p1;
    logic [CHANNELS-1:0] active;

    // Stage p0/p1: synchroniser, loaded with the idle pin level in reset
    always_ff @(posedge clock_27mhz) begin
        if (!reset_b) begin
            sync_p0 <= IDLE_RAW;
            sync_p1 <= IDLE_RAW;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    assign active = sync_p1 ^ IDLE_RAW;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [DC_W-1:0] dc_q;
        logic [DC_W-1:0] dc_d;
        logic [RT_W-1:0] rt_q;
        logic [RT_W-1:0] rt_d;
        logic            level_q;
        logic            level_d;
        logic            press_q;
        logic            release_q;
        logic            strobe_q;
        logic            strobe_d;
        logic            rise;
        logic            fall;

        always_comb begin
            dc_d     = '0;
            level_d  = level_q;
            rt_d     = RT_DELAY;
            strobe_d = 1'b0;
            if (active[ch] != level_q) begin
                if (dc_q == DC_LAST) begin
                    level_d = active[ch];
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            rise = level_d & ~level_q;
            fall = level_q & ~level_d;
            // The repeat timer only runs while the key stays held on both sides of the edge
            if (rise) begin
                strobe_d = 1'b1;
            end else if (level_q && level_d && repeat_en[ch]) begin
                if (rt_q != '0) begin
                    rt_d = rt_q - 1'b1;
                end else begin
                    strobe_d = 1'b1;
                    rt_d     = RT_PERIOD;
                end
            end
        end

        // Stage p2: debounced level, edge pulses and repeat strobe
        always_ff @(posedge clock_27mhz) begin
            if (!reset_b) begin
                dc_q      <= '0;
                rt_q      <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                strobe_q  <= 1'b0;
            end else begin
                dc_q      <= dc_d;
                rt_q      <= rt_d;
                level_q   <= level_d;
                press_q   <= rise;
                release_q <= fall;
                strobe_q  <= strobe_d;
            end
        end

        assign level[ch]         = level_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = release_q;
        assign strobe[ch]        = strobe_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat constants.
module tb_button_conditioner;

    logic       clock_27mhz = 1'b0;
    logic       reset_b;
    logic [3:0] raw_in;
    logic [3:0] repeat_en;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;
    logic [3:0] strobe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock_27mhz = ~clock_27mhz;

    button_conditioner #(
        .CHANNELS        (4),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock_27mhz   (clock_27mhz),
        .reset_b       (reset_b),
        .raw_in        (raw_in),
        .repeat_en     (repeat_en),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .strobe        (strobe)
    );

    task automatic tick();
        @(posedge clock_27mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] s);
        chk({tag, " level"},   level,         l);
        chk({tag, " press"},   press,         p);
        chk({tag, " release"}, release_pulse, r);
        chk({tag, " strobe"},  strobe,        s);
    endtask

    initial begin
        logic [3:0] el, ep, er, es;

        // 1: reset with all pins idle, then quiet period
        reset_b   = 1'b0;
        raw_in    = 4'hF;
        repeat_en = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("t1 reset c%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
        end
        reset_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all($sformatf("t1 idle c%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // 2: clean press and release on channel 0
        raw_in[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            el = (k >= 6 && k < 26) ? 4'b0001 : 4'b0000;
            ep = (k == 6)  ? 4'b0001 : 4'b0000;
            er = (k == 26) ? 4'b0001 : 4'b0000;
            chk_all($sformatf("t2 k%0d", k), el, ep, er, ep);
            if (k == 20) raw_in[0] = 1'b1;
        end

        // 3: 3-cycle glitches on channel 1 never accepted
        for (int rep = 0; rep < 5; rep++) begin
            raw_in[1] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk_all($sformatf("t3 r%0d lo%0d", rep, i), 4'h0, 4'h0, 4'h0, 4'h0);
            end
            raw_in[1] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk_all($sformatf("t3 r%0d hi%0d", rep, i), 4'h0, 4'h0, 4'h0, 4'h0);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all($sformatf("t3 tail%0d", i), 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // 4: auto-repeat on channel 2, press at k=6, repeats at 16 and 19, then disabled
        repeat_en[2] = 1'b1;
        raw_in[2]    = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            el = (k >= 6) ? 4'b0100 : 4'b0000;
            ep = (k == 6) ? 4'b0100 : 4'b0000;
            es = (k == 6 || k == 16 || k == 19) ? 4'b0100 : 4'b0000;
            chk_all($sformatf("t4 k%0d", k), el, ep, 4'h0, es);
            if (k == 20) repeat_en[2] = 1'b0;
        end
        raw_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            el = (k < 6) ? 4'b0100 : 4'b0000;
            er = (k == 6) ? 4'b0100 : 4'b0000;
            chk_all($sformatf("t4 rel k%0d", k), el, 4'h0, er, 4'h0);
        end

        // 5: simultaneous press on channels 0 and 3, repeat disabled
        raw_in = 4'b0110;
        for (int k = 1; k <= 30; k++) begin
            tick();
            el = (k >= 6) ? 4'b1001 : 4'b0000;
            ep = (k == 6) ? 4'b1001 : 4'b0000;
            chk_all($sformatf("t5 k%0d", k), el, ep, 4'h0, ep);
        end

        // 6: one-cycle reset while keys held gives a fresh press 6 cycles later
        reset_b = 1'b0;
        tick();
        chk_all("t6 in reset", 4'h0, 4'h0, 4'h0, 4'h0);
        reset_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            el = (k >= 6) ? 4'b1001 : 4'b0000;
            ep = (k == 6) ? 4'b1001 : 4'b0000;
            chk_all($sformatf("t6 k%0d", k), el, ep, 4'h0, ep);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
